// File: rtl/motoro3_deadtime_gate_if.sv
// rtl/motoro3_deadtime_gate_if.sv - request/gate-drive bundle between commutation logic and motoro3_deadtime_gate
interface motoro3_deadtime_gate_if #(
    parameter int DT_W = 8
);
    logic [1:0]      reqA;
    logic [1:0]      reqB;
    logic [1:0]      reqC;
    logic [DT_W-1:0] dtCycles;
    logic            flt;
    logic            fltClr;
    logic            aH;
    logic            aL;
    logic            bH;
    logic            bL;
    logic            cH;
    logic            cL;
    logic            fltLatched;
    logic            reqErr;
    logic            busy;

    modport master (
        output reqA, reqB, reqC, dtCycles, flt, fltClr,
        input  aH, aL, bH, bL, cH, cL, fltLatched, reqErr, busy
    );

    modport slave (
        input  reqA, reqB, reqC, dtCycles, flt, fltClr,
        output aH, aL, bH, bL, cH, cL, fltLatched, reqErr, busy
    );
endinterface

// File: rtl/motoro3_deadtime_gate.sv
// rtl/motoro3_deadtime_gate.sv - three-phase gate drive with dead-time insertion, fault latch and sticky request error
// Optional minimum on-time enforcement is enabled by defining MOTORO3_DT_MIN_ON_EN.
module motoro3_deadtime_gate #(
`ifdef MOTORO3_DT_MIN_ON_EN
    parameter int MIN_ON = 4,
`endif
    parameter int DT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    motoro3_deadtime_gate_if.slave gate
);
    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_HI  = 2'd1,
        ST_LO  = 2'd2
    } state_e;

    localparam logic [1:0] REQ_HI  = 2'b10;
    localparam logic [1:0] REQ_LO  = 2'b01;
    localparam logic [1:0] REQ_ILL = 2'b11;

    logic [1:0]      req [3];
    state_e          state_q [3];
    state_e          state_d [3];
    logic [DT_W-1:0] cnt_q [3];
    logic [DT_W-1:0] cnt_d [3];
    logic            flt_latched_q;
    logic            flt_latched_d;
    logic            req_err_q;
    logic            req_err_d;
    logic            force_off;
    logic [2:0]      leave_ok;
    logic [2:0]      drv_h;
    logic [2:0]      drv_l;
    logic [2:0]      pend;

    assign req[0]    = gate.reqA;
    assign req[1]    = gate.reqB;
    assign req[2]    = gate.reqC;
    // The raw fault input forces OFF on the very next edge, before the latch itself is visible.
    assign force_off = gate.flt | flt_latched_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
            flt_latched_q <= 1'b0;
            req_err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            flt_latched_q <= flt_latched_d;
            req_err_q     <= req_err_d;
        end
    end

`ifdef MOTORO3_DT_MIN_ON_EN
    localparam int ON_W = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;

    logic [ON_W-1:0] on_tmr_q [3];
    logic [ON_W-1:0] on_tmr_d [3];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                on_tmr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                on_tmr_q[i] <= on_tmr_d[i];
            end
        end
    end

    // Timer sits at zero while OFF, so it starts from zero on every entry to HI or LO.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            on_tmr_d[i] = on_tmr_q[i];
            leave_ok[i] = int'(on_tmr_q[i]) >= (MIN_ON - 1);
            if (state_q[i] == ST_OFF) begin
                on_tmr_d[i] = '0;
            end else if (!leave_ok[i]) begin
                on_tmr_d[i] = on_tmr_q[i] + ON_W'(1);
            end
        end
    end
`else
    assign leave_ok = 3'b111;
`endif

    always_comb begin
        flt_latched_d = flt_latched_q;
        req_err_d     = req_err_q;
        if (gate.fltClr && !gate.flt) begin
            flt_latched_d = 1'b0;
            req_err_d     = 1'b0;
        end
        if (gate.flt) begin
            flt_latched_d = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (req[i] == REQ_ILL) begin
                req_err_d = 1'b1;
            end
        end

        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (force_off) begin
                state_d[i] = ST_OFF;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_OFF: begin
                        if (cnt_q[i] != '1) begin
                            cnt_d[i] = cnt_q[i] + DT_W'(1);
                        end
                        if (cnt_q[i] >= gate.dtCycles) begin
                            if (req[i] == REQ_HI) begin
                                state_d[i] = ST_HI;
                            end else if (req[i] == REQ_LO) begin
                                state_d[i] = ST_LO;
                            end
                        end
                    end
                    ST_HI: begin
                        if (req[i] != REQ_HI && leave_ok[i]) begin
                            state_d[i] = ST_OFF;
                            cnt_d[i]   = '0;
                        end
                    end
                    ST_LO: begin
                        if (req[i] != REQ_LO && leave_ok[i]) begin
                            state_d[i] = ST_OFF;
                            cnt_d[i]   = '0;
                        end
                    end
                    default: begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        drv_h = '0;
        drv_l = '0;
        pend  = '0;
        for (int i = 0; i < 3; i++) begin
            drv_h[i] = (state_q[i] == ST_HI);
            drv_l[i] = (state_q[i] == ST_LO);
            pend[i]  = (state_q[i] == ST_OFF) && ((req[i] == REQ_HI) || (req[i] == REQ_LO));
        end
    end

    assign gate.aH         = drv_h[0];
    assign gate.aL         = drv_l[0];
    assign gate.bH         = drv_h[1];
    assign gate.bL         = drv_l[1];
    assign gate.cH         = drv_h[2];
    assign gate.cL         = drv_l[2];
    assign gate.fltLatched = flt_latched_q;
    assign gate.reqErr     = req_err_q;
    assign gate.busy       = |pend;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((drv_h & drv_l) == 3'b000);
        end
    end
endmodule

// File: tb/tb_motoro3_deadtime_gate.sv
// tb/tb_motoro3_deadtime_gate.sv - directed self-checking bench for motoro3_deadtime_gate
module tb_motoro3_deadtime_gate;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    motoro3_deadtime_gate_if #(.DT_W(8)) gif ();

    motoro3_deadtime_gate #(.DT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .gate (gif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {gif.aH, gif.aL, gif.bH, gif.bL, gif.cH, gif.cL};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("h_and_l_overlap", 32'({gif.aH & gif.aL, gif.bH & gif.bL, gif.cH & gif.cL}), 32'd0);
    endtask

    initial begin
        logic [1:0] side;
        logic       exp_h;
        checks = 0;
        errors = 0;

        rst          = 1'b1;
        gif.reqA     = 2'b00;
        gif.reqB     = 2'b00;
        gif.reqC     = 2'b00;
        gif.dtCycles = 8'd5;
        gif.flt      = 1'b0;
        gif.fltClr   = 1'b0;
        repeat (3) tick();
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_fltLatched", 32'(gif.fltLatched), 32'd0);
        chk("reset_reqErr", 32'(gif.reqErr), 32'd0);
        chk("reset_busy", 32'(gif.busy), 32'd0);

        rst      = 1'b0;
        gif.reqA = 2'b10;
        #1;
        chk("release_busy", 32'(gif.busy), 32'd1);
        repeat (5) tick();
        chk("first_on_edge5_aH", 32'(gif.aH), 32'd0);
        tick();
        chk("first_on_edge6_aH", 32'(gif.aH), 32'd1);
        chk("first_on_aL", 32'(gif.aL), 32'd0);

        gif.dtCycles = 8'd3;
        gif.reqA     = 2'b01;
        tick();
        chk("rev_n1_a", 32'({gif.aH, gif.aL}), 32'b00);
        chk("rev_n1_busy", 32'(gif.busy), 32'd1);
        repeat (3) tick();
        chk("rev_n4_aL", 32'(gif.aL), 32'd0);
        tick();
        chk("rev_n5_a", 32'({gif.aH, gif.aL}), 32'b01);

        gif.dtCycles = 8'd0;
        gif.reqB     = 2'b10;
        tick();
        chk("dt0_first_b", 32'({gif.bH, gif.bL}), 32'b10);
        for (int k = 0; k < 4; k++) begin
            side     = (k % 2 == 0) ? 2'b01 : 2'b10;
            gif.reqB = side;
            tick();
            chk("dt0_gap_b", 32'({gif.bH, gif.bL}), 32'b00);
            chk("dt0_gap_busy", 32'(gif.busy), 32'd1);
            tick();
            chk("dt0_on_b", 32'({gif.bH, gif.bL}), 32'(side));
            chk("dt0_on_busy", 32'(gif.busy), 32'd0);
        end

        gif.dtCycles = 8'd2;
        gif.reqC     = 2'b10;
        tick();
        chk("all_driven", 32'(outs()), 32'b011010);
        gif.flt = 1'b1;
        tick();
        chk("flt_outs", 32'(outs()), 32'd0);
        chk("flt_latched", 32'(gif.fltLatched), 32'd1);
        gif.flt = 1'b0;
        tick();
        chk("flt_hold_outs", 32'(outs()), 32'd0);
        gif.flt    = 1'b1;
        gif.fltClr = 1'b1;
        tick();
        chk("flt_wins_clr", 32'(gif.fltLatched), 32'd1);
        gif.flt    = 1'b0;
        gif.fltClr = 1'b0;
        tick();
        chk("flt_still_latched", 32'(gif.fltLatched), 32'd1);
        gif.fltClr = 1'b1;
        tick();
        gif.fltClr = 1'b0;
        chk("clr_latched", 32'(gif.fltLatched), 32'd0);
        chk("clr_outs", 32'(outs()), 32'd0);
        tick();
        chk("clr_c1_outs", 32'(outs()), 32'd0);
        chk("clr_c1_busy", 32'(gif.busy), 32'd1);
        tick();
        chk("clr_c2_outs", 32'(outs()), 32'd0);
        tick();
        chk("clr_c3_outs", 32'(outs()), 32'b011010);

        gif.reqC = 2'b11;
        tick();
        chk("ill_c", 32'({gif.cH, gif.cL}), 32'b00);
        chk("ill_reqErr", 32'(gif.reqErr), 32'd1);
        gif.reqC = 2'b00;
        tick();
        chk("ill_sticky", 32'(gif.reqErr), 32'd1);
        chk("ill_busy", 32'(gif.busy), 32'd0);
        gif.fltClr = 1'b1;
        tick();
        gif.fltClr = 1'b0;
        chk("ill_cleared", 32'(gif.reqErr), 32'd0);

        gif.reqA = 2'b00;
        tick();
        chk("minon_pre_off", 32'({gif.aH, gif.aL}), 32'b00);
        gif.dtCycles = 8'd0;
        gif.reqA     = 2'b10;
        tick();
        chk("minon_entry", 32'(gif.aH), 32'd1);
        gif.reqA = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            tick();
`ifdef MOTORO3_DT_MIN_ON_EN
            exp_h = (k < 4);
`else
            exp_h = 1'b0;
`endif
            chk("minon_aH", 32'(gif.aH), 32'(exp_h));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
